// File: rtl/buffer_filas_pkg.sv
// Shared definitions for the row-buffer controller: activation codes, FSM
// states and default geometry of the buffer_unidad array.
package buffer_filas_pkg;

  localparam int unsigned N_UNIDADES_DEF  = 8;
  localparam int unsigned PROF_UNIDAD_DEF = 8;

  localparam logic [1:0] ACT_MANTENER  = 2'b00;
  localparam logic [1:0] ACT_ACTIVA    = 2'b01;
  localparam logic [1:0] ACT_NO_ACTIVA = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LIMPIAR = 3'd1,
    CONFIG  = 3'd2,
    LLENAR  = 3'd3,
    FLUJO   = 3'd4,
    FIN     = 3'd5
  } estado_t;

  // ceil(ancho / 2**log2_prof) using add-and-shift only
  function automatic int unsigned unidades_req(input int unsigned ancho,
                                               input int unsigned log2_prof);
    return (ancho + (32'd1 << log2_prof) - 32'd1) >> log2_prof;
  endfunction

endpackage

// File: rtl/control_buffer_filas_contador.sv
// Column/row position tracker for one frame; flags the last pixel of each
// line and of the frame while the increment enable is high.
module contador_linea_cuadro #(
  parameter int unsigned ANCHO_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [ANCHO_W-1:0] ancho_i,
  input  logic [ANCHO_W-1:0] alto_i,
  output logic               fin_linea_o,
  output logic               fin_cuadro_o
);

  localparam logic [ANCHO_W-1:0] UNO = ANCHO_W'(1);

  logic [ANCHO_W-1:0] col_q, col_d;
  logic [ANCHO_W-1:0] fila_q, fila_d;
  logic               ult_col, ult_fila;

  assign ult_col      = (col_q == ancho_i - UNO);
  assign ult_fila     = (fila_q == alto_i - UNO);
  assign fin_linea_o  = en_i & ult_col;
  assign fin_cuadro_o = fin_linea_o & ult_fila;

  always_comb begin
    col_d  = col_q;
    fila_d = fila_q;
    if (clr_i) begin
      col_d  = '0;
      fila_d = '0;
    end else if (en_i) begin
      if (ult_col) begin
        col_d  = '0;
        fila_d = ult_fila ? '0 : fila_q + UNO;
      end else begin
        col_d = col_q + UNO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q  <= '0;
      fila_q <= '0;
    end else begin
      col_q  <= col_d;
      fila_q <= fila_d;
    end
  end

endmodule

// File: rtl/control_buffer_filas.sv
// Upstream controller for the buffer_unidad row buffer: per-frame clear and
// activation, fill-then-stream request gating and line/frame markers.
module control_buffer_filas
  import buffer_filas_pkg::*;
#(
  parameter int unsigned N_UNIDADES  = N_UNIDADES_DEF,
  parameter int unsigned PROF_UNIDAD = PROF_UNIDAD_DEF,
  parameter int unsigned ANCHO_W     = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ANCHO_W-1:0]      ancho_imagen,
  input  logic [ANCHO_W-1:0]      alto_imagen,
  input  logic                    pixel_valid,
  output logic                    buffers_sclr,
  output logic [2*N_UNIDADES-1:0] valor_activacion,
  output logic                    write_req,
  output logic                    read_req,
  output logic                    fin_linea,
  output logic                    fin_cuadro,
  output logic                    error_cfg,
  output logic                    ocupado
);

  localparam int unsigned LOG2_PROF = $clog2(PROF_UNIDAD);
  localparam int unsigned CAPACIDAD = N_UNIDADES * PROF_UNIDAD;

  estado_t                 state_q, state_d;
  logic [ANCHO_W-1:0]      ancho_q, alto_q;
  logic                    sclr_q;
  logic [2*N_UNIDADES-1:0] act_q, act_d;
  logic                    err_q, err_d;
  logic                    ocupado_q;
  logic                    cfg_mala, carga;
  logic                    en_pix, fin_l, fin_c;
  int unsigned             n_req;

  assign cfg_mala = (ancho_imagen == '0) || (alto_imagen == '0) ||
                    (32'(ancho_imagen) > CAPACIDAD);
  assign carga    = (state_q == IDLE) && start && !cfg_mala;
  assign n_req    = unidades_req(32'(ancho_q), LOG2_PROF);

  // Strobes and line/frame markers must coincide with the accepted pixel,
  // so they are decoded from registered state and the live pixel_valid.
  assign en_pix    = pixel_valid && (state_q == LLENAR || state_q == FLUJO);
  assign write_req = en_pix;
  assign read_req  = pixel_valid && (state_q == FLUJO);
  assign fin_linea  = fin_l;
  assign fin_cuadro = fin_c;

  assign buffers_sclr     = sclr_q;
  assign valor_activacion = act_q;
  assign error_cfg        = err_q;
  assign ocupado          = ocupado_q;

  contador_linea_cuadro #(.ANCHO_W(ANCHO_W)) u_contador (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (state_q == LIMPIAR),
    .en_i         (en_pix),
    .ancho_i      (ancho_q),
    .alto_i       (alto_q),
    .fin_linea_o  (fin_l),
    .fin_cuadro_o (fin_c)
  );

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_mala) err_d = 1'b1;
          else          state_d = LIMPIAR;
        end
      end
      LIMPIAR: state_d = CONFIG;
      CONFIG:  state_d = LLENAR;
      LLENAR: begin
        if (fin_c)      state_d = FIN;
        else if (fin_l) state_d = FLUJO;
      end
      FLUJO: if (fin_c) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    act_d = '0;
    if (state_d == CONFIG) begin
      for (int unsigned i = 0; i < N_UNIDADES; i++) begin
        act_d[2*i +: 2] = (i < n_req) ? ACT_ACTIVA : ACT_NO_ACTIVA;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ancho_q   <= '0;
      alto_q    <= '0;
      sclr_q    <= 1'b0;
      act_q     <= '0;
      err_q     <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (carga) begin
        ancho_q <= ancho_imagen;
        alto_q  <= alto_imagen;
      end
      sclr_q    <= (state_d == LIMPIAR);
      act_q     <= act_d;
      err_q     <= err_d;
      ocupado_q <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_control_buffer_filas.sv
// Directed bench for control_buffer_filas: per-cycle expected output vectors
// go through a scoreboard queue and are compared mid-cycle.
module tb_control_buffer_filas;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  ancho_imagen;
  logic [7:0]  alto_imagen;
  logic        pixel_valid;
  logic        buffers_sclr;
  logic [15:0] valor_activacion;
  logic        write_req;
  logic        read_req;
  logic        fin_linea;
  logic        fin_cuadro;
  logic        error_cfg;
  logic        ocupado;

  control_buffer_filas #(
    .N_UNIDADES  (8),
    .PROF_UNIDAD (8),
    .ANCHO_W     (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .ancho_imagen     (ancho_imagen),
    .alto_imagen      (alto_imagen),
    .pixel_valid      (pixel_valid),
    .buffers_sclr     (buffers_sclr),
    .valor_activacion (valor_activacion),
    .write_req        (write_req),
    .read_req         (read_req),
    .fin_linea        (fin_linea),
    .fin_cuadro       (fin_cuadro),
    .error_cfg        (error_cfg),
    .ocupado          (ocupado)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       tag;
    logic [22:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   wr_cnt = 0;
  int   rd_cnt = 0;

  // {ocupado, error_cfg, sclr, fin_cuadro, fin_linea, read, write, activacion}
  function automatic logic [22:0] mk(input logic oc, input logic er, input logic sc,
                                     input logic fc, input logic fl, input logic rd,
                                     input logic wr, input logic [15:0] act);
    return {oc, er, sc, fc, fl, rd, wr, act};
  endfunction

  task automatic paso(input logic st, input logic pv, input string tag,
                      input logic [22:0] v);
    exp_t        e;
    logic [22:0] obs;
    start       = st;
    pixel_valid = pv;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
    @(negedge clk);
    obs = {ocupado, error_cfg, buffers_sclr, fin_cuadro, fin_linea,
           read_req, write_req, valor_activacion};
    if (write_req === 1'b1) wr_cnt++;
    if (read_req === 1'b1)  rd_cnt++;
    e = sb.pop_front();
    n_total++;
    assert (obs === e.v) n_pass++;
    else $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.v);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic frame_run(input logic [7:0] a, input logic [7:0] h,
                           input logic [15:0] act);
    int n;
    n = int'(a) * int'(h);
    ancho_imagen = a;
    alto_imagen  = h;
    paso(1'b1, 1'b0, "arranque", '0);
    paso(1'b0, 1'b0, "sclr", mk(1, 0, 1, 0, 0, 0, 0, '0));
    paso(1'b0, 1'b0, "activacion", mk(1, 0, 0, 0, 0, 0, 0, act));
    wr_cnt = 0;
    rd_cnt = 0;
    for (int p = 1; p <= n; p++)
      paso(1'b0, 1'b1, $sformatf("pixel%0d", p),
           mk(1, 0, 0, p == n, (p % int'(a)) == 0, p > int'(a), 1, '0));
    chk("n_write", wr_cnt, n);
    chk("n_read", rd_cnt, int'(a) * (int'(h) - 1));
    paso(1'b0, 1'b1, "fin_estado", mk(1, 0, 0, 0, 0, 0, 0, '0));
    paso(1'b0, 1'b0, "vuelta_idle", '0);
  endtask

  task automatic bad_cfg(input logic [7:0] a, input logic [7:0] h);
    ancho_imagen = a;
    alto_imagen  = h;
    paso(1'b1, 1'b0, "cfg_arranque", '0);
    paso(1'b0, 1'b0, "cfg_error", mk(0, 1, 0, 0, 0, 0, 0, '0));
    paso(1'b0, 1'b0, "cfg_despues", '0);
  endtask

  initial begin
    int k;
    logic pv;
    reset        = 1'b1;
    start        = 1'b0;
    pixel_valid  = 1'b0;
    ancho_imagen = '0;
    alto_imagen  = '0;
    @(posedge clk);
    #1;
    paso(1'b0, 1'b1, "reset", '0);
    reset = 1'b0;
    paso(1'b0, 1'b1, "idle_pixel_ignorado", '0);

    frame_run(8'd20, 8'd3, 16'hAA95);

    // gapped input, ancho=8 alto=2
    ancho_imagen = 8'd8;
    alto_imagen  = 8'd2;
    paso(1'b1, 1'b0, "gap_arranque", '0);
    paso(1'b0, 1'b0, "gap_sclr", mk(1, 0, 1, 0, 0, 0, 0, '0));
    paso(1'b0, 1'b0, "gap_act", mk(1, 0, 0, 0, 0, 0, 0, 16'hAAA9));
    wr_cnt = 0;
    rd_cnt = 0;
    k = 0;
    for (int i = 0; i < 32; i++) begin
      pv = (i % 2) == 0;
      if (pv) begin
        k++;
        paso(1'b0, 1'b1, $sformatf("gap_pix%0d", k),
             mk(1, 0, 0, k == 16, (k % 8) == 0, k > 8, 1, '0));
      end else begin
        paso(1'b0, 1'b0, "gap_hueco", mk(1, 0, 0, 0, 0, 0, 0, '0));
      end
    end
    chk("gap_n_write", wr_cnt, 16);
    chk("gap_n_read", rd_cnt, 8);
    paso(1'b0, 1'b0, "gap_idle", '0);

    bad_cfg(8'd65, 8'd3);
    bad_cfg(8'd0, 8'd3);
    bad_cfg(8'd20, 8'd0);

    frame_run(8'd64, 8'd1, 16'h5555);
    frame_run(8'd1, 8'd2, 16'hAAA9);

    // interference: start during FLUJO, then reset mid-FLUJO
    ancho_imagen = 8'd8;
    alto_imagen  = 8'd3;
    paso(1'b1, 1'b0, "int_arranque", '0);
    paso(1'b0, 1'b0, "int_sclr", mk(1, 0, 1, 0, 0, 0, 0, '0));
    paso(1'b0, 1'b0, "int_act", mk(1, 0, 0, 0, 0, 0, 0, 16'hAAA9));
    for (int p = 1; p <= 12; p++)
      paso(p == 10, 1'b1, $sformatf("int_pix%0d", p),
           mk(1, 0, 0, 0, p == 8, p > 8, 1, '0));
    reset = 1'b1;
    paso(1'b0, 1'b1, "int_ciclo_reset", mk(1, 0, 0, 0, 0, 1, 1, '0));
    reset = 1'b0;
    paso(1'b0, 1'b1, "int_tras_reset", '0);
    paso(1'b1, 1'b1, "int_arranque_ignorado_no", '0);
    paso(1'b0, 1'b0, "int_sclr2", mk(1, 0, 1, 0, 0, 0, 0, '0));
    paso(1'b0, 1'b0, "int_act2", mk(1, 0, 0, 0, 0, 0, 0, 16'hAAA9));
    for (int p = 1; p <= 24; p++)
      paso(1'b0, 1'b1, $sformatf("int2_pix%0d", p),
           mk(1, 0, 0, p == 24, (p % 8) == 0, p > 8, 1, '0));
    paso(1'b0, 1'b0, "int2_fin", mk(1, 0, 0, 0, 0, 0, 0, '0));
    paso(1'b0, 1'b0, "int2_idle", '0);

    frame_run(8'd4, 8'd2, 16'hAAA9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
